// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a DATA_IN / TRG_WRITE / DONE handshake,
// with CTS gating, a sticky overflow flag and a sticky DONE-timeout flag.
module uart_tx_queue #(
  parameter int DEPTH_LOG2     = 4,
  parameter int PULSE_CYCLES   = 5,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  CLK_50MHZ,
  input  logic                  RST,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
  input  logic                  CTS,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  TIMEOUT_ERR,
  output logic                  BUSY,
  output logic [7:0]            UART_DATA_IN,
  output logic                  UART_TRG_WRITE,
  output logic                  UART_FLOW,
  input  logic                  UART_DONE
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES);

  localparam logic [PW-1:0]         PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]         TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT} state_t;

  state_t state_reg, state_next;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  full_reg, empty_reg;
  logic                  overflow_reg, tmo_err_reg;
  logic                  trg_reg, done_d_reg;
  logic [7:0]            data_reg;
  logic [PW-1:0]         pulse_cnt_reg;
  logic [TW-1:0]         tmo_cnt_reg;

  logic push, pop, end_pulse, tmo_hit, done_evt;

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign push     = WR_EN && !full_reg;
  assign done_evt = UART_DONE && !done_d_reg;

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    end_pulse  = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_reg && CTS) begin
          pop        = 1'b1;
          state_next = TRIG;
        end
      end
      TRIG: begin
        if (pulse_cnt_reg == PULSE_LAST) begin
          end_pulse  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (done_evt) begin
          state_next = IDLE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CNT_ONE;
    else if (!push && pop) count_next = count_reg - CNT_ONE;
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge CLK_50MHZ) begin
    if (push) mem[wr_ptr_reg] <= WR_DATA;
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      overflow_reg  <= 1'b0;
      tmo_err_reg   <= 1'b0;
      trg_reg       <= 1'b0;
      done_d_reg    <= 1'b0;
      data_reg      <= 8'h00;
      pulse_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      done_d_reg <= UART_DONE;
      count_reg  <= count_next;
      full_reg   <= (count_next == DEPTH_CNT);
      empty_reg  <= (count_next == '0);
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (WR_EN && full_reg) overflow_reg <= 1'b1;
      if (pop) begin
        data_reg      <= mem[rd_ptr_reg];
        rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
        trg_reg       <= 1'b1;
        pulse_cnt_reg <= '0;
      end
      if (state_reg == TRIG) pulse_cnt_reg <= pulse_cnt_reg + PW'(1);
      if (state_reg == WAIT) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      if (end_pulse) begin
        trg_reg     <= 1'b0;
        tmo_cnt_reg <= '0;
      end
      if (tmo_hit) tmo_err_reg <= 1'b1;
    end
  end

  assign FULL           = full_reg;
  assign EMPTY          = empty_reg;
  assign COUNT          = count_reg;
  assign OVERFLOW       = overflow_reg;
  assign TIMEOUT_ERR    = tmo_err_reg;
  assign BUSY           = (state_reg != IDLE);
  assign UART_DATA_IN   = data_reg;
  assign UART_TRG_WRITE = trg_reg;
  assign UART_FLOW      = 1'b1;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed stimulus queues expected bytes; a negedge monitor
// checks each UART trigger against that queue plus pulse width and COUNT/FULL/EMPTY.
module tb_uart_tx_queue;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int PULSE = 5;
  localparam int TMO   = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       cts = 1'b1;
  logic       uart_done = 1'b0;

  logic         full, empty, overflow, tmo_err, busy, trg, flow;
  logic [DL2:0] count;
  logic [7:0]   data_in;

  uart_tx_queue #(.DEPTH_LOG2(DL2), .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_50MHZ(clk), .RST(rst_n), .WR_DATA(wr_data), .WR_EN(wr_en), .CTS(cts),
    .FULL(full), .EMPTY(empty), .COUNT(count), .OVERFLOW(overflow),
    .TIMEOUT_ERR(tmo_err), .BUSY(busy), .UART_DATA_IN(data_in),
    .UART_TRG_WRITE(trg), .UART_FLOW(flow), .UART_DONE(uart_done)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int cyc = 0, acc_cnt = 0, trig_cnt = 0;
  int trig_cyc = 0, done_cyc = 0, width = 0, peak = 0, model_cnt = 0;
  logic trg_prev = 1'b0;
  bit uart_en = 1'b1;
  bit rand_delay = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Occupancy model: bytes accepted (counted at the consuming edge) minus bytes triggered.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) acc_cnt = 0;
    else if (wr_en && (acc_cnt - trig_cnt) < DEPTH) acc_cnt++;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      trig_cnt = 0;
      trg_prev = 1'b0;
      width    = 0;
      exp_q.delete();
    end else begin
      if (trg && !trg_prev) begin
        trig_cnt++;
        trig_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", int'(data_in), -1);
        end else begin
          exp_byte = exp_q.pop_front();
          chk("byte_order", int'(data_in), int'(exp_byte));
          $display("tx byte 0x%02h (expected 0x%02h) cycle %0d", data_in, exp_byte, cyc);
        end
      end
      if (trg) width++;
      else if (trg_prev) begin
        chk("pulse_width", width, PULSE);
        width = 0;
      end
      trg_prev  = trg;
      model_cnt = acc_cnt - trig_cnt;
      chk("count_model", int'(count), model_cnt);
      chk("empty_model", int'(empty), (model_cnt == 0) ? 1 : 0);
      chk("full_model", int'(full), (model_cnt == DEPTH) ? 1 : 0);
      if (int'(count) > peak) peak = int'(count);
    end
  end

  // UART model: one-cycle DONE pulse a fixed or random number of clocks after each trigger.
  initial begin
    int d;
    forever begin
      @(posedge trg);
      if (uart_en) begin
        d = rand_delay ? int'($urandom_range(6, 12)) : 20;
        repeat (d) @(posedge clk);
        #1 uart_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk);
        #1 uart_done = 1'b0;
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] b, input bit accepted);
    wr_en   = 1'b1;
    wr_data = b;
    if (accepted) exp_q.push_back(b);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_trigs(input int target, input int budget, input string name);
    int n = 0;
    while (trig_cnt < target && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk({"wait_", name}, (trig_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || !empty) && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk({"idle_busy_", name}, int'(busy), 0);
    chk({"idle_empty_", name}, int'(empty), 1);
  endtask

  initial begin
    int base, n;
    rst_n = 1'b0;
    idle_cycles(3);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_tmo", int'(tmo_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_trg", int'(trg), 0);
    chk("rst_data", int'(data_in), 0);
    chk("flow_const", int'(flow), 1);
    rst_n = 1'b1;
    idle_cycles(2);

    // T1: reset in the middle of a trigger pulse
    drive(8'hA5, 1'b1);
    drive(8'h5A, 1'b1);
    chk("t1_trg_high", int'(trg), 1);
    chk("t1_data", int'(data_in), 8'hA5);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_trg_drop", int'(trg), 0);
    chk("t1_busy_drop", int'(busy), 0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    chk("t1_empty", int'(empty), 1);
    chk("t1_count", int'(count), 0);
    chk("t1_overflow", int'(overflow), 0);
    chk("t1_tmo", int'(tmo_err), 0);
    chk("t1_data_clr", int'(data_in), 0);
    $display("T1 reset done");
    idle_cycles(30);

    // T2: single byte, trigger one clock after the write
    base = trig_cnt;
    drive(8'h03, 1'b1);
    chk("t2_trg_not_yet", int'(trg), 0);
    chk("t2_count_one", int'(count), 1);
    idle_cycles(1);
    chk("t2_trg_start", int'(trg), 1);
    chk("t2_data", int'(data_in), 8'h03);
    chk("t2_busy", int'(busy), 1);
    wait_trigs(base + 1, 10, "t2");
    wait_idle(100, "t2");
    chk("t2_sb_drained", exp_q.size(), 0);

    // T3: burst of three, next trigger 1 clock after DONE is seen
    base = trig_cnt;
    peak = 0;
    drive(8'h03, 1'b1);
    drive(8'h06, 1'b1);
    drive(8'h0C, 1'b1);
    wait_trigs(base + 2, 200, "t3_b2");
    chk("t3_gap2", trig_cyc - done_cyc, 2);
    wait_trigs(base + 3, 200, "t3_b3");
    chk("t3_gap3", trig_cyc - done_cyc, 2);
    wait_idle(100, "t3");
    chk("t3_peak", peak, 2);
    chk("t3_sb_drained", exp_q.size(), 0);

    // T4: fill with CTS low, overflow on the 17th byte
    cts  = 1'b0;
    base = trig_cnt;
    for (int i = 0; i < 16; i++) drive(8'(i), 1'b1);
    chk("t4_full", int'(full), 1);
    chk("t4_count16", int'(count), 16);
    chk("t4_no_ovf_yet", int'(overflow), 0);
    drive(8'h10, 1'b0);
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_count_held", int'(count), 16);
    chk("t4_cts_hold", int'(busy), 0);
    cts = 1'b1;
    wait_trigs(base + 16, 16 * 40, "t4");
    wait_idle(100, "t4");
    chk("t4_sent16", trig_cnt - base, 16);
    chk("t4_sb_drained", exp_q.size(), 0);

    // T5: DONE never arrives for the first byte
    uart_en = 1'b0;
    base = trig_cnt;
    drive(8'h77, 1'b1);
    drive(8'h88, 1'b1);
    wait_trigs(base + 1, 10, "t5_b1");
    n = 0;
    while (trg && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_wait_entry", int'(trg), 0);
    repeat (TMO - 1) @(negedge clk);
    chk("t5_tmo_early", int'(tmo_err), 0);
    chk("t5_busy_waiting", int'(busy), 1);
    @(negedge clk);
    chk("t5_tmo_set", int'(tmo_err), 1);
    uart_en = 1'b1;
    wait_trigs(base + 2, 20, "t5_b2");
    wait_idle(100, "t5");
    chk("t5_tmo_sticky", int'(tmo_err), 1);
    chk("t5_sb_drained", exp_q.size(), 0);

    // T6: 40 random bytes, random gaps and UART latency, pushes overlap pops
    rand_delay = 1'b1;
    base = trig_cnt;
    for (int i = 0; i < 40; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      n = 0;
      while ((acc_cnt - trig_cnt) >= DEPTH && n < 400) begin
        idle_cycles(1);
        n++;
      end
      drive(8'($urandom), 1'b1);
    end
    wait_trigs(base + 40, 40 * 40, "t6");
    wait_idle(100, "t6");
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 20000);
    errors++;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
